// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_sequencer_pkg;

    // FSM state codes; the debug port exposes these values directly
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    // PC mux select: sequential PC+4 or ALU-computed target
    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_TGT = 1'b1;

    // Memory-ack watchdog limit in cycles; 0 disables the watchdog
    localparam int DEFAULT_TIMEOUT = 16;

    // Counter width able to hold TIMEOUT-1 (at least one bit)
    function automatic int wd_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/cpu_sequencer_mem_watchdog.sv
// Counts consecutive un-acked IF/MEM wait cycles and flags expiry at TIMEOUT-1.
// Latency: expiry is combinational in the cycle the counter sits at TIMEOUT-1.
// Backpressure: none; an ack in the expiry cycle suppresses the flag.
module cpu_sequencer_mem_watchdog
    import cpu_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int             W     = wd_width(TIMEOUT);
    localparam logic [W-1:0]   LIMIT = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;
    localparam logic           WD_ON = (TIMEOUT > 0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wait_cyc;

    // A wait cycle is one spent in IF/MEM with no ack; anything else is a
    // state transition (or idle state), which clears the count.
    assign wait_cyc  = active_i & ~ack_i;
    assign expired_o = WD_ON & wait_cyc & (cnt_q == LIMIT);

    // Next count: advance on wait cycles, clear on ack, expiry or leaving IF/MEM
    always_comb begin
        cnt_d = '0;
        if (WD_ON && wait_cyc && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM with halt, memory watchdog and retire count.
// Latency: ALU ops 4 cycles, load/store 5 cycles with immediate acks.
// Backpressure: IF and MEM hold their requests until ack or watchdog expiry.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    output logic             dec_en,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             reg_we,
    input  logic             is_halt,
    input  logic             br_taken,
    output logic             exec_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             halted,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             wd_active;
    logic             wd_ack;
    logic             wd_expired;
    logic             run;

    // One watchdog shared by both wait states; only the ack of the current
    // state can end a wait, the other ack is ignored.
    assign wd_active = (state_q == ST_IF) || (state_q == ST_MEM);
    assign wd_ack    = (state_q == ST_IF) ? imem_ack : dmem_ack;

    cpu_sequencer_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk       (clk),
        .rst       (rst),
        .active_i  (wd_active),
        .ack_i     (wd_ack),
        .expired_o (wd_expired)
    );

    // Next-state, sticky flags and retire count
    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        bus_err_d = bus_err_q;
        retire_d  = retire_q;
        case (state_q)
            ST_IF: begin
                if (imem_ack) begin
                    state_d = ST_ID;
                end else if (wd_expired) begin
                    state_d   = ST_HALT;
                    halted_d  = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            ST_ID: state_d = ST_EX;
            ST_EX: begin
                if (is_halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    state_d   = ST_HALT;
                    halted_d  = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            ST_WB: begin
                state_d  = ST_IF;
                retire_d = retire_q + 1'b1;
            end
            ST_HALT: halted_d = 1'b1;
            default: begin
                // Corrupted state code: park and flag as an error
                state_d   = ST_HALT;
                halted_d  = 1'b1;
                bus_err_d = 1'b1;
            end
        endcase
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IF;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
            retire_q  <= retire_d;
        end
    end

    // Strobes decode the registered state; all are held low while in reset
    assign run      = ~rst;
    assign imem_req = run && (state_q == ST_IF);
    assign ir_we    = run && (state_q == ST_IF) && imem_ack;
    assign dec_en   = run && (state_q == ST_ID);
    assign exec_en  = run && (state_q == ST_EX);
    assign dmem_req = run && (state_q == ST_MEM);
    assign dmem_we  = run && (state_q == ST_MEM) && is_store;
    assign rf_we    = run && (state_q == ST_WB) && reg_we;
    assign pc_we    = run && (state_q == ST_WB);
    assign pc_sel   = (run && (state_q == ST_WB) && br_taken) ? PC_SEL_TGT : PC_SEL_SEQ;

    assign halted     = halted_q;
    assign bus_err    = bus_err_q;
    assign state      = state_q;
    assign retire_cnt = retire_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the single-issue RV32I core.
- Sequences fetch, decode, execute, memory access and writeback around the existing decoder, ALU, register file and memories.
- Drives the decoder's update strobe, memory request handshakes, and the PC/register-file write enables.
- Detects halt and memory-timeout conditions and counts retired instructions.

Parameters:
- TIMEOUT, 16: max cycles a memory request may wait for its ack before abort; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction word valid this cycle
- ir_we  out  1  latch instruction register
- dec_en  out  1  decoder update strobe (drives decoder recalculate input)
- is_load  in  1  from decoder
- is_store  in  1  from decoder
- reg_we  in  1  from decoder
- is_halt  in  1  from decoder
- br_taken  in  1  ALU branch/jump redirect result
- exec_en  out  1  latch ALU result register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ack  in  1  data access complete
- rf_we  out  1  register file write enable
- pc_we  out  1  PC update enable
- pc_sel  out  1  0 = PC+4, 1 = ALU target
- halted  out  1  sticky halt indicator
- bus_err  out  1  sticky timeout indicator
- state  out  3  current FSM state (debug)
- retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). While rst is high, all strobes are forced to 0.
- Reset values at the clock edge with rst=1: state=IF, retire_cnt=0, halted=0, bus_err=0, watchdog counter=0.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to HALT with bus_err=1.
- Outputs are Moore functions of state, except ir_we, rf_we, pc_sel and dmem_we, which are defined below.
- IF:
  - imem_req=1, held until imem_ack.
  - Cycle with imem_ack=1: ir_we=1, next state ID.
- ID:
  - dec_en=1 for exactly one cycle, then next state EX.
  - Decoder outputs are valid from the EX cycle onward.
- EX:
  - exec_en=1 for one cycle.
  - Next state priority: is_halt → HALT; else is_load|is_store → MEM; else WB.
- MEM:
  - dmem_req=1 and dmem_we=is_store, both held until dmem_ack.
  - Cycle with dmem_ack=1: next state WB.
- WB (one cycle):
  - rf_we=reg_we; pc_we=1; pc_sel=br_taken.
  - retire_cnt+1, wrapping modulo 2^CNT_W.
  - Next state IF.
- HALT:
  - Absorbing until rst. halted=1; all strobes 0; retire_cnt frozen.
  - The halting instruction does not retire and does not update the PC.
- Watchdog:
  - Counter clears on every state transition.
  - Increments each IF/MEM cycle without the corresponding ack.
  - When it reaches TIMEOUT-1 with no ack in that cycle: next state HALT, bus_err=1, halted=1.
  - An ack arriving in that same cycle wins; no error is raised.
- Latency from IF entry with ack in the first IF cycle:
  - ALU/branch/jump: 4 cycles.
  - Load/store with immediate dmem_ack: 5 cycles.
- Acks are ignored outside their matching state.
- Reset mid-operation: any pending request drops the cycle after the rst edge; no rf_we/pc_we is issued.

Decomposition:
- Shared package (alongside the ALU/opcode defines):
  - state codes (ST_IF … ST_HALT)
  - PC_SEL_SEQ/PC_SEL_TGT constants
  - default TIMEOUT.
- One natural sub-module: mem_watchdog (counter, clear, expiry compare), instantiated once and shared by IF/MEM.

Test Plan:
- ADD instruction, imem_ack in first IF cycle → ir_we at cycle 0, dec_en at cycle 1, exec_en at cycle 2, rf_we=1 and pc_we=1 at cycle 3; retire_cnt 0→1.
- LW, dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; WB on the following cycle with rf_we=1; total 8 cycles.
- SW, then BEQ with br_taken=1 → store cycle has dmem_we=1 and rf_we=0; branch WB has pc_sel=1 and rf_we=0.
- is_halt in EX → HALT next cycle, halted=1; imem_req stays 0 for 20 cycles; retire_cnt unchanged.
- TIMEOUT=4, imem_ack never asserted → imem_req high 4 cycles, then state=HALT with bus_err=1. Repeat with ack on the 4th cycle → no error, ID entered.
- rst asserted during MEM with dmem_req=1 → next cycle state=IF, dmem_req=0, retire_cnt=0, halted=0.
